uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the transmit side of `uart_comm` (output word buffer plus serializer) between N_CLIENTS word producers.
- Grants one client at a time, round-robin, for a burst of up to MAX_BURST 32-bit words. The burst ends on the client's last flag or at MAX_BURST.
- Drives `uart_comm` `w_buff_out`/`data_from_system` directly and throttles on `full_out`.
- Sits between system-side producers (echo path, status reporters) and the `uart_comm` instance.

Parameters:
- N_CLIENTS, 4, number of requesters; 2..8.
- WORD_SIZE, 32, word width written to the UART output buffer.
- MAX_BURST, 16, maximum words per grant before forced rotation; >=1.
- ID_W, $clog2(N_CLIENTS), width of grant index.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cl_valid  in  N_CLIENTS  client i has a word on cl_data slice i
- cl_last  in  N_CLIENTS  word presented by client i is the final word of its packet
- cl_data  in  N_CLIENTS*WORD_SIZE  flattened client words; slice i = bits [i*WORD_SIZE +: WORD_SIZE]
- cl_ready  out  N_CLIENTS  word of client i is accepted this cycle
- full_out  in  1  `uart_comm` output buffer full
- empty_out  in  1  `uart_comm` output buffer empty
- w_buff_out  out  1  write strobe into `uart_comm` output buffer
- data_from_system  out  WORD_SIZE  word written into `uart_comm`
- grant_valid  out  1  a client currently owns the transmitter
- grant_id  out  ID_W  index of owning client
- burst_done  out  1  one-cycle pulse when a burst terminates

Behaviour:
- Reset values: state IDLE, rr_ptr=0, grant_id=0, grant_valid=0, beat_cnt=0, burst_done=0. cl_ready, w_buff_out and data_from_system evaluate to 0.
- States: IDLE, XFER, DRAIN.
- IDLE:
  - If any cl_valid is set, pick the first set bit scanning from rr_ptr upward with wrap.
  - Register grant_id, set grant_valid=1, beat_cnt=0, go to XFER.
  - The decision takes 1 cycle. No word is accepted in IDLE.
- XFER handshake, combinational:
  - cl_ready[i] = (state==XFER) && (grant_id==i) && !full_out.
  - Accept when cl_valid[grant_id] && cl_ready[grant_id].
  - w_buff_out = accept.
  - data_from_system = cl_data slice grant_id when accept, else 0.
  - Zero added latency client-to-buffer.
  - While full_out=1, nothing is accepted and the state holds. The client must keep valid/data stable.
- Each accept increments beat_cnt.
- Burst termination: on an accept with cl_last[grant_id]=1, or with beat_cnt==MAX_BURST-1:
  - Pulse burst_done the next cycle (registered).
  - Set rr_ptr = grant_id+1 (wrapping to 0 past N_CLIENTS-1).
  - Clear grant_valid.
  - Go to IDLE, or to DRAIN if the optional feature is enabled.
- Granted client drops valid mid-burst: the grant is held and the arbiter waits indefinitely; no timeout.
- Non-granted clients see cl_ready=0 regardless of full_out.
- Simultaneous requests: strict round-robin from rr_ptr. After client k finishes, client k+1 wins over k even if k requests again.
- MAX_BURST=1: every accepted word ends the burst.
- Reset mid-burst: immediate return to reset values. A partially written packet in `uart_comm` is not retracted.

Optional Feature:
- Macro UART_ARB_DRAIN_EN.
- Defined:
  - After burst termination, go to DRAIN with grant_valid=0.
  - Stay in DRAIN until empty_out==1, then go to IDLE.
  - Guarantees one client's packet is fully serialized before another's enters the buffer.
- Undefined: DRAIN is never entered; termination goes straight to IDLE, so bursts are back-to-back in the buffer.

Decomposition:
- Shared package `uart_pkg`:
  - typedef enum arb_state_t {IDLE, XFER, DRAIN}.
  - Default constants WORD_SIZE_DEF=32, MAX_BURST_DEF=16.
- Sub-module rr_picker:
  - Purely combinational.
  - Inputs: req vector, rr_ptr. Outputs: winner index, any_req.
  - Reusable for a future receive-side dispatcher.

Test Plan:
- Single client: client 2 sends 3 words 0xA1,0xA2,0xA3 (last on third), full_out=0 -> w_buff_out high 3 consecutive cycles after 1-cycle grant; data matches in order; burst_done pulses once; grant_id=2.
- Contention: clients 0,1,3 all valid with 1-word packets from reset -> grant order 0,1,3; after 3 ends, a new request from 0 wins next.
- Forced rotation: MAX_BURST=4; client 1 streams 10 words with no last while client 2 waits -> client 1 gets 4 words, client 2 is granted next, then client 1 resumes.
- Backpressure: full_out asserted for 5 cycles mid-burst -> cl_ready=0 and w_buff_out=0 throughout; the held word is written exactly once after release; no duplication or loss.
- Drain (UART_ARB_DRAIN_EN): client 0 packet ends with empty_out=0 for 20 cycles -> client 1 not granted until the cycle after empty_out=1. Without the macro, client 1 is granted 1 cycle after burst_done.
- Async reset asserted mid-burst at word 2 of 5 -> all outputs 0 on the same edge; after release, arbitration restarts from client 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side arbiter and helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int WORD_SIZE_DEF = 32;
    localparam int MAX_BURST_DEF = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_picker #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            any_req
);

    // Scan from the farthest candidate back to ptr so the closest one wins last.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                winner  = ID_W'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter feeding the uart_comm output buffer.
// Define UART_ARB_DRAIN_EN to wait for the buffer to empty between bursts.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int ID_W      = $clog2(N_CLIENTS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_CLIENTS-1:0]           cl_valid,
    input  logic [N_CLIENTS-1:0]           cl_last,
    input  logic [N_CLIENTS*WORD_SIZE-1:0] cl_data,
    output logic [N_CLIENTS-1:0]           cl_ready,
    input  logic                           full_out,
    input  logic                           empty_out,
    output logic                           w_buff_out,
    output logic [WORD_SIZE-1:0]           data_from_system,
    output logic                           grant_valid,
    output logic [ID_W-1:0]                grant_id,
    output logic                           burst_done
);

    localparam int BC_W = $clog2(MAX_BURST) + 1;

    arb_state_t      r_state;
    arb_state_t      w_next_state;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_grant_id;
    logic            r_grant_valid;
    logic            r_burst_done;
    logic [BC_W-1:0] r_beat_cnt;
    logic [ID_W-1:0] w_winner;
    logic            w_any_req;
    logic            w_accept;
    logic            w_term;

    rr_picker #(
        .N    (N_CLIENTS),
        .ID_W (ID_W)
    ) u_picker (
        .req     (cl_valid),
        .ptr     (r_rr_ptr),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (w_any_req) w_next_state = XFER;
            XFER: begin
                if (w_term) begin
`ifdef UART_ARB_DRAIN_EN
                    w_next_state = DRAIN;
`else
                    w_next_state = IDLE;
`endif
                end
            end
            DRAIN: if (empty_out) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake is purely combinational so an accepted word reaches the buffer in the same cycle.
    always_comb begin
        cl_ready         = '0;
        w_buff_out       = 1'b0;
        data_from_system = '0;
        w_accept         = 1'b0;
        w_term           = 1'b0;
        if (r_state == XFER && !full_out) begin
            cl_ready[r_grant_id] = 1'b1;
            w_accept             = cl_valid[r_grant_id];
        end
        if (w_accept) begin
            w_buff_out       = 1'b1;
            data_from_system = cl_data[int'(r_grant_id)*WORD_SIZE +: WORD_SIZE];
            w_term           = cl_last[r_grant_id] || (r_beat_cnt == BC_W'(MAX_BURST - 1));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_beat_cnt    <= '0;
            r_burst_done  <= 1'b0;
        end else begin
            r_burst_done <= w_term;
            if (r_state == IDLE && w_any_req) begin
                r_grant_id    <= w_winner;
                r_grant_valid <= 1'b1;
                r_beat_cnt    <= '0;
            end
            if (w_accept) r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_term) begin
                r_grant_valid <= 1'b0;
                r_rr_ptr      <= (r_grant_id == ID_W'(N_CLIENTS - 1)) ? '0 : r_grant_id + 1'b1;
            end
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign burst_done  = r_burst_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_CLIENTS=4, MAX_BURST=4); follows UART_ARB_DRAIN_EN if defined.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   cl_valid = '0;
    logic [N-1:0]   cl_last  = '0;
    logic [N*W-1:0] cl_data  = '0;
    logic           full_out  = 1'b0;
    logic           empty_out = 1'b1;
    logic [N-1:0]   cl_ready;
    logic           w_buff_out;
    logic [W-1:0]   data_from_system;
    logic           grant_valid;
    logic [1:0]     grant_id;
    logic           burst_done;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int wr_base  = 0;

    uart_tx_arbiter #(
        .N_CLIENTS (N),
        .WORD_SIZE (W),
        .MAX_BURST (MB)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .cl_valid         (cl_valid),
        .cl_last          (cl_last),
        .cl_data          (cl_data),
        .cl_ready         (cl_ready),
        .full_out         (full_out),
        .empty_out        (empty_out),
        .w_buff_out       (w_buff_out),
        .data_from_system (data_from_system),
        .grant_valid      (grant_valid),
        .grant_id         (grant_id),
        .burst_done       (burst_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (w_buff_out === 1'b1) wr_cnt <= wr_cnt + 1;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [31:0] v);
        cl_data[i*W +: W] = v;
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] id);
        int n;
        n = 0;
        while (grant_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_gv"}, 64'(grant_valid), 64'd1);
        chk({tag, "_id"}, 64'(grant_id), 64'(id));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        settle();
        reset = 1'b0;
        cl_valid = '0;
        cl_last  = '0;
        full_out = 1'b0;
        step();
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_gv",    64'(grant_valid), 64'd0);
        chk("rst_gid",   64'(grant_id), 64'd0);
        chk("rst_wbuf",  64'(w_buff_out), 64'd0);
        chk("rst_ready", 64'(cl_ready), 64'd0);
        chk("rst_data",  64'(data_from_system), 64'd0);
        chk("rst_bdone", 64'(burst_done), 64'd0);
        #10;
        reset = 1'b0;
        step();

        // Single client 2, three words
        wr_base  = wr_cnt;
        cl_valid = 4'b0100;
        set_word(2, 32'hA1);
        settle();
        chk("t1_idle_wbuf",  64'(w_buff_out), 64'd0);
        chk("t1_idle_ready", 64'(cl_ready), 64'd0);
        step();
        chk("t1_gv",    64'(grant_valid), 64'd1);
        chk("t1_gid",   64'(grant_id), 64'd2);
        chk("t1_ready", 64'(cl_ready), 64'b0100);
        chk("t1_w0",    64'(w_buff_out), 64'd1);
        chk("t1_d0",    64'(data_from_system), 64'hA1);
        step();
        set_word(2, 32'hA2);
        settle();
        chk("t1_w1", 64'(w_buff_out), 64'd1);
        chk("t1_d1", 64'(data_from_system), 64'hA2);
        step();
        set_word(2, 32'hA3);
        cl_last = 4'b0100;
        settle();
        chk("t1_w2",    64'(w_buff_out), 64'd1);
        chk("t1_d2",    64'(data_from_system), 64'hA3);
        chk("t1_bd_lo", 64'(burst_done), 64'd0);
        step();
        cl_valid = '0;
        cl_last  = '0;
        settle();
        chk("t1_bd_hi",  64'(burst_done), 64'd1);
        chk("t1_gv_off", 64'(grant_valid), 64'd0);
        chk("t1_wbuf_off", 64'(w_buff_out), 64'd0);
        step();
        chk("t1_bd_once", 64'(burst_done), 64'd0);
        chk("t1_wrcnt",   64'(wr_cnt - wr_base), 64'd3);

        // Contention: clients 0,1,3 with one-word packets
        pulse_reset();
        cl_valid = 4'b1011;
        cl_last  = 4'b1111;
        set_word(0, 32'hC0);
        set_word(1, 32'hC1);
        set_word(3, 32'hC3);
        step();
        chk("t2_g0_id", 64'(grant_id), 64'd0);
        chk("t2_g0_d",  64'(data_from_system), 64'hC0);
        step();
        cl_valid[0] = 1'b0;
        settle();
        chk("t2_bd0", 64'(burst_done), 64'd1);
        wait_grant("t2_g1", 2'd1);
        chk("t2_g1_d", 64'(data_from_system), 64'hC1);
        step();
        cl_valid[1] = 1'b0;
        wait_grant("t2_g3", 2'd3);
        chk("t2_g3_d", 64'(data_from_system), 64'hC3);
        step();
        cl_valid = 4'b0101;
        set_word(0, 32'hD0);
        set_word(2, 32'hD2);
        wait_grant("t2_g0b", 2'd0);
        chk("t2_g0b_d", 64'(data_from_system), 64'hD0);
        step();
        cl_valid = '0;
        step();

        // Forced rotation at MAX_BURST=4
        pulse_reset();
        cl_valid = 4'b0110;
        cl_last  = 4'b0100;
        set_word(2, 32'hE2);
        set_word(1, 32'h100);
        step();
        chk("t3_g1_id", 64'(grant_id), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk("t3_c1_data", 64'(data_from_system), 64'(32'h100 + k));
            step();
            set_word(1, 32'h101 + k);
            settle();
        end
        chk("t3_bd",    64'(burst_done), 64'd1);
        chk("t3_gv_off", 64'(grant_valid), 64'd0);
        wait_grant("t3_c2", 2'd2);
        chk("t3_c2_d", 64'(data_from_system), 64'hE2);
        step();
        cl_valid[2] = 1'b0;
        wait_grant("t3_c1r", 2'd1);
        chk("t3_c1r_d", 64'(data_from_system), 64'h104);
        step();
        cl_valid = '0;
        step();
        step();
        step();
        chk("t3_hold_gv",   64'(grant_valid), 64'd1);
        chk("t3_hold_id",   64'(grant_id), 64'd1);
        chk("t3_hold_wbuf", 64'(w_buff_out), 64'd0);

        // Backpressure for 5 cycles mid-burst
        pulse_reset();
        wr_base  = wr_cnt;
        cl_valid = 4'b1000;
        set_word(3, 32'hF0);
        step();
        chk("t4_d0", 64'(data_from_system), 64'hF0);
        step();
        set_word(3, 32'hF1);
        full_out = 1'b1;
        settle();
        chk("t4_full_ready", 64'(cl_ready), 64'd0);
        chk("t4_full_wbuf",  64'(w_buff_out), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_ready", 64'(cl_ready), 64'd0);
            chk("t4_hold_wbuf",  64'(w_buff_out), 64'd0);
        end
        full_out = 1'b0;
        settle();
        chk("t4_rel_ready", 64'(cl_ready), 64'b1000);
        chk("t4_rel_d1",    64'(data_from_system), 64'hF1);
        step();
        set_word(3, 32'hF2);
        cl_last = 4'b1000;
        settle();
        chk("t4_d2", 64'(data_from_system), 64'hF2);
        step();
        cl_valid = '0;
        cl_last  = '0;
        settle();
        chk("t4_bd",    64'(burst_done), 64'd1);
        chk("t4_wrcnt", 64'(wr_cnt - wr_base), 64'd3);

        // Drain behaviour between client 0 and client 1
        step();
        step();
        empty_out = 1'b0;
        cl_valid  = 4'b0011;
        cl_last   = 4'b0011;
        set_word(0, 32'h50);
        set_word(1, 32'h51);
        wait_grant("t5_c0", 2'd0);
        chk("t5_c0_d", 64'(data_from_system), 64'h50);
        step();
        cl_valid[0] = 1'b0;
        settle();
        chk("t5_bd", 64'(burst_done), 64'd1);
`ifdef UART_ARB_DRAIN_EN
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_drain_hold", 64'(grant_valid), 64'd0);
        end
        empty_out = 1'b1;
        step();
        chk("t5_drain_exit", 64'(grant_valid), 64'd0);
        step();
`else
        step();
`endif
        chk("t5_c1_gv", 64'(grant_valid), 64'd1);
        chk("t5_c1_id", 64'(grant_id), 64'd1);
        step();
        cl_valid  = '0;
        cl_last   = '0;
        empty_out = 1'b1;
        step();

        // Reset in the middle of a five-word burst
        step();
        cl_valid = 4'b0001;
        set_word(0, 32'h60);
        wait_grant("t6_g0", 2'd0);
        step();
        set_word(0, 32'h61);
        step();
        set_word(0, 32'h62);
        settle();
        chk("t6_w2", 64'(w_buff_out), 64'd1);
        reset = 1'b1;
        settle();
        chk("t6_rst_gv",    64'(grant_valid), 64'd0);
        chk("t6_rst_wbuf",  64'(w_buff_out), 64'd0);
        chk("t6_rst_data",  64'(data_from_system), 64'd0);
        chk("t6_rst_ready", 64'(cl_ready), 64'd0);
        chk("t6_rst_bd",    64'(burst_done), 64'd0);
        cl_valid = 4'b0101;
        cl_last  = 4'b0101;
        settle();
        reset = 1'b0;
        step();
        chk("t6_restart_gv", 64'(grant_valid), 64'd1);
        chk("t6_restart_id", 64'(grant_id), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
